// File: rtl/dlx_fetch.sv
// DLX instruction-fetch stage: holds the PC, fetches over a ready handshake,
// and computes the next PC from branch/jump decode once the datapath retires.
module dlx_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  input  logic        exec_done,
  input  logic        branch_z,
  input  logic        branch_nz,
  input  logic        jmp,
  input  logic        jmp_r,
  input  logic [31:0] bus_a,
  output logic [31:0] retired,
  output logic        misalign
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {FETCH, HOLD} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_d, inst_d, retired_d;
  logic              inst_valid_d, misalign_d, imem_req_d;
  logic [XLEN-1:0]   seq_pc, next_pc;
  logic              taken;

  assign imem_addr = pc;
  assign link_addr = pc + XLEN'(4);
  assign seq_pc    = pc + XLEN'(4);

  // Next-PC select; both branch flags high means either condition takes it
  always_comb begin
    taken = (branch_z && (bus_a == '0)) || (branch_nz && (bus_a != '0));
    if (jmp_r)
      next_pc = {bus_a[31:2], 2'b00};
    else if (jmp)
      next_pc = seq_pc + {{6{inst[25]}}, inst[25:0]};
    else if (taken)
      next_pc = seq_pc + {{16{inst[15]}}, inst[15:0]};
    else
      next_pc = seq_pc;
  end

  // FSM next-state and registered-output next values; imem_req gates acceptance
  always_comb begin
    state_d      = state_q;
    pc_d         = pc;
    inst_d       = inst;
    inst_valid_d = inst_valid;
    retired_d    = retired;
    misalign_d   = 1'b0;
    imem_req_d   = imem_req;
    case (state_q)
      FETCH: begin
        if (imem_req && imem_ready) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          imem_req_d   = 1'b0;
          state_d      = HOLD;
        end else begin
          imem_req_d   = 1'b1;
        end
      end
      HOLD: begin
        if (exec_done) begin
          pc_d         = next_pc;
          inst_valid_d = 1'b0;
          retired_d    = retired + XLEN'(1);
          misalign_d   = jmp_r && (bus_a[1:0] != 2'b00);
          imem_req_d   = 1'b1;
          state_d      = FETCH;
        end
      end
      default: begin
        state_d    = FETCH;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
      retired    <= '0;
      misalign   <= 1'b0;
      imem_req   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      inst       <= inst_d;
      inst_valid <= inst_valid_d;
      retired    <= retired_d;
      misalign   <= misalign_d;
      imem_req   <= imem_req_d;
    end
  end

endmodule

// File: doc/dlx_fetch.md
# dlx_fetch

Instruction-fetch stage for the 32-bit DLX datapath. Holds the program counter and requests instructions from instruction memory over a ready handshake. Presents each fetched word as `inst` to the downstream control decoder and datapath. Once the datapath signals completion, computes the next PC from the decoder's branch and jump outputs and the register operand.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request; held until accepted
- `imem_addr`  out  32  fetch address; always equals `pc`
- `imem_ready`  in  1  memory has `imem_rdata` valid this cycle; meaningful only while `imem_req`=1
- `imem_rdata`  in  32  instruction word
- `inst`  out  32  registered instruction to the decoder
- `inst_valid`  out  1  `inst` holds a live instruction
- `pc`  out  32  address of `inst`
- `link_addr`  out  32  `pc`+4, write data for JAL/JALR
- `exec_done`  in  1  datapath has finished `inst`; next-PC inputs are valid this cycle
- `branch_z`, `branch_nz`, `jmp`, `jmp_r`  in  1 each  decoder outputs for the current `inst`
- `bus_a`  in  32  rs1 register value (branch test, JR/JALR target)
- `retired`  out  32  count of completed instructions; wraps
- `misalign`  out  1  one-cycle pulse when a JR/JALR target has nonzero bits [1:0]

## Operation
- FSM with two states:
  - FETCH: `imem_req`=1. On `imem_ready`=1: `inst`<=`imem_rdata`, `inst_valid`<=1, go to HOLD. Otherwise stay in FETCH.
  - HOLD: `imem_req`=0. `imem_ready` is ignored. On `exec_done`=1: `pc`<=next_pc, `inst_valid`<=0, `retired`<=`retired`+1, go to FETCH. Otherwise stay in HOLD with `inst` stable.
- In FETCH, `exec_done` is ignored.
- Next PC, with seq = `pc`+4. Priority, highest first:
  - `jmp_r`: {`bus_a`[31:2],2'b00}. `misalign` pulses if `bus_a`[1:0]≠0.
  - `jmp`: seq + sext(`inst`[25:0]).
  - Taken branch: seq + sext(`inst`[15:0]). Taken means (`branch_z` and `bus_a`==0) or (`branch_nz` and `bus_a`≠0).
  - Otherwise: seq.
- All adds are modulo 2^32, with no overflow detection. PC wrap from 32'hFFFF_FFFC to 0 is legal.
- If `branch_z` and `branch_nz` are both high, the branch is taken if either condition holds.
- `link_addr` = `pc`+4 at all times. It is combinational from `pc`.
- `inst` is updated only on the FETCH→HOLD transition.

## Timing
- Reset values while `rst`=1 at a clock edge: `pc`=`RESET_PC`, `inst`=0, `inst_valid`=0, `retired`=0, `misalign`=0, `imem_req`=0, state=FETCH.
- `imem_req` rises in the first cycle after `rst` deasserts.
- `rst` asserted mid-fetch or mid-hold aborts the cycle. Any returning `imem_ready` is ignored while `rst`=1.
- Fetch latency: `inst_valid` rises the cycle after `imem_ready` is sampled high.
- Instruction throughput is at most one per 2 cycles: FETCH with immediate ready, then HOLD with immediate `exec_done`.
- `pc`/`imem_addr` change the cycle after `exec_done`. `imem_req` is high in that same cycle, with the new address.
- `misalign` is registered. It is high for exactly the one cycle following the `exec_done` that took the misaligned JR.
- `exec_done` and `imem_ready` high together in HOLD: only `exec_done` acts.

## Test plan
- Reset with `RESET_PC`=32'h100, `imem_ready` tied 1, `exec_done` tied 1, all control inputs 0 → fetch addresses 0x100, 0x104, 0x108. `retired`=3 after three HOLD exits. `inst_valid` pattern is 0,1,0,1,….
- `imem_ready` delayed 3 cycles at `pc`=0x200 → `imem_req` and `imem_addr`=0x200 hold steady for 3 cycles. `inst_valid` rises exactly one cycle after ready.
- Taken BEQZ at `pc`=0x40, `inst`[15:0]=16'hFFF8, `bus_a`=0 → next `pc`=0x3C. Same with `bus_a`=5 → 0x44. BNEZ with `bus_a`=5 → 0x3C.
- J at `pc`=0x1000 with `inst`[25:0]=26'h0000100 → `pc`=0x1104. `link_addr` reads 0x1004 while the J is held.
- JR with `bus_a`=32'h0000_2003 → `pc`=0x2000 and `misalign` pulses one cycle. `jmp` and `jmp_r` both high → `jmp_r` wins.
- Assert `rst` in HOLD with `exec_done`=1 → `pc`=`RESET_PC` and `retired`=0; no increment. `pc`=32'hFFFF_FFFC sequential → wraps to 0.
